// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler: sequential round-robin matcher emitting a full ingress-to-egress permutation
module crossbar_scheduler #(
    parameter  int EGRESS_CNT = 4,
    localparam int SEL_W      = $clog2(EGRESS_CNT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [EGRESS_CNT*EGRESS_CNT-1:0] voq_req,
    output logic [SEL_W*EGRESS_CNT-1:0]      sched_sel,
    output logic [EGRESS_CNT-1:0]            sched_en,
    output logic                             sched_valid,
    output logic                             busy
);
    localparam int N = EGRESS_CNT;
    typedef enum logic [1:0] {IDLE, MATCH, DONE} state_t;
    state_t                     state_q, state_d;
    logic [N*N-1:0]             req_q, req_d;
    logic [SEL_W-1:0]           step_q, step_d, base_q, base_d;
    logic [N-1:0][SEL_W-1:0]    ptr_q, ptr_d, wsel_q, wsel_d, sel_q, sel_d, fsel;
    logic [N-1:0]               mi_q, mi_d, me_q, me_d, en_q, en_d, fme;
    logic [SEL_W-1:0]           k, cand;
    logic                       found, fdone;
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        step_d  = step_q;
        base_d  = base_q;
        ptr_d   = ptr_q;
        wsel_d  = wsel_q;
        mi_d    = mi_q;
        me_d    = me_q;
        sel_d   = sel_q;
        en_d    = en_q;
        k       = base_q + step_q;
        found   = 1'b0;
        cand    = '0;
        // req_q[{i, k}] addresses bit i*N+k since N is a power of two
        for (int o = 0; o < N; o++)
            if (!found && req_q[{ptr_q[k] + SEL_W'(o), k}] && !mi_q[ptr_q[k] + SEL_W'(o)]) begin
                found = 1'b1;
                cand  = ptr_q[k] + SEL_W'(o);
            end
        if (state_q == IDLE && start) begin
            state_d = MATCH;
            req_d   = voq_req;
            step_d  = '0;
            mi_d    = '0;
            me_d    = '0;
            wsel_d  = '0;
        end else if (state_q == MATCH) begin
            if (found) begin
                wsel_d[cand] = k;
                mi_d[cand]   = 1'b1;
                me_d[k]      = 1'b1;
                ptr_d[k]     = cand + SEL_W'(1);
            end
            step_d  = step_q + SEL_W'(1);
            state_d = (step_q == SEL_W'(N - 1)) ? DONE : MATCH;
        end else if (state_q == DONE) begin
            state_d = IDLE;
            base_d  = base_q + SEL_W'(1);
        end
        // Fill is taken from the post-step copies so the result is registered on entry to DONE
        fme   = me_d;
        fsel  = wsel_d;
        fdone = 1'b0;
        for (int i = 0; i < N; i++) begin
            fdone = mi_d[i];
            for (int j = 0; j < N; j++)
                if (!fdone && !fme[j]) begin
                    fsel[i] = SEL_W'(j);
                    fme[j]  = 1'b1;
                    fdone   = 1'b1;
                end
        end
        if (state_q == MATCH && step_q == SEL_W'(N - 1)) begin
            sel_d = fsel;
            en_d  = mi_d;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            step_q  <= '0;
            base_q  <= '0;
            ptr_q   <= '0;
            wsel_q  <= '0;
            mi_q    <= '0;
            me_q    <= '0;
            en_q    <= '0;
            for (int i = 0; i < N; i++) sel_q[i] <= SEL_W'(i);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            step_q  <= step_d;
            base_q  <= base_d;
            ptr_q   <= ptr_d;
            wsel_q  <= wsel_d;
            mi_q    <= mi_d;
            me_q    <= me_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end
    assign sched_sel   = sel_q;
    assign sched_en    = en_q;
    assign sched_valid = (state_q == DONE);
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_crossbar_scheduler.sv
// tb_crossbar_scheduler: table vectors, corner sequences and a reference model feeding a scoreboard
module tb_crossbar_scheduler;
    localparam int N = 4;
    localparam int W = 2;
    logic             clk = 1'b0;
    logic             reset, start;
    logic [N*N-1:0]   voq_req;
    logic [W*N-1:0]   sched_sel;
    logic [N-1:0]     sched_en;
    logic             sched_valid, busy;
    int               errs = 0;
    int               checks = 0;
    typedef struct packed {logic [W*N-1:0] sel; logic [N-1:0] en;} res_t;
    typedef struct {bit rst; logic [15:0] req; logic [7:0] sel; logic [3:0] en;} vec_t;
    res_t  sbq[$];
    res_t  m, mon_e, tmp;
    vec_t  vecs[5];
    int    m_ptr[N];
    int    m_base;
    logic  dup;
    logic [15:0] r;
    always #5 clk = ~clk;
    crossbar_scheduler #(.EGRESS_CNT(N)) dut (
        .clk(clk), .reset(reset), .start(start), .voq_req(voq_req),
        .sched_sel(sched_sel), .sched_en(sched_en), .sched_valid(sched_valid), .busy(busy)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    function automatic res_t model(input logic [15:0] rq);
        res_t o;
        logic [N-1:0] mi = '0, me = '0;
        int s[N];
        for (int i = 0; i < N; i++) s[i] = -1;
        for (int c = 0; c < N; c++) begin
            int kk = (m_base + c) % N;
            for (int d = 0; d < N; d++) begin
                int ii = (m_ptr[kk] + d) % N;
                if (rq[ii*N+kk] && !mi[ii]) begin
                    s[ii] = kk; mi[ii] = 1'b1; me[kk] = 1'b1; m_ptr[kk] = (ii + 1) % N;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (!mi[i])
                for (int j = 0; j < N; j++)
                    if (!me[j]) begin s[i] = j; me[j] = 1'b1; break; end
        for (int i = 0; i < N; i++) o.sel[i*W+:W] = W'(s[i]);
        o.en = mi;
        m_base = (m_base + 1) % N;
        return o;
    endfunction
    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        m_base = 0;
        for (int i = 0; i < N; i++) m_ptr[i] = 0;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    // Full schedule: start in cycle 0, busy 1..N+1, valid only in N+1, idle in N+2
    task automatic sched(input logic [15:0] rq, input logic [7:0] es, input logic [3:0] ee);
        res_t e;
        e.sel = es; e.en = ee;
        sbq.push_back(e);
        voq_req = rq; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 1; c <= N + 1; c++) begin
            chk($sformatf("busy_c%0d", c), busy, 1);
            chk($sformatf("valid_c%0d", c), sched_valid, (c == N + 1));
            if (c <= N) tick();
        end
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_valid", sched_valid, 0);
        chk("sb_drained", sbq.size(), 0);
    endtask
    always @(negedge clk) if (!reset) begin
        dup = 1'b0;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (sched_sel[a*W+:W] == sched_sel[b*W+:W]) dup = 1'b1;
        chk("sel_distinct", dup, 0);
        if (sched_valid) begin
            if (sbq.size() == 0) chk("spurious_valid", sched_valid, 0);
            else begin
                mon_e = sbq.pop_front();
                chk("sched_sel", sched_sel, mon_e.sel);
                chk("sched_en", sched_en, mon_e.en);
            end
        end
    end
    initial begin
        voq_req = '0;
        reset = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        chk("rst_sel", sched_sel, 8'hE4);
        chk("rst_en", sched_en, 0);
        chk("rst_valid", sched_valid, 0);
        chk("rst_busy", busy, 0);
        vecs[0] = '{rst: 1'b0, req: 16'hFFFF, sel: 8'hE4, en: 4'b1111};
        vecs[1] = '{rst: 1'b0, req: 16'hFFFF, sel: 8'h93, en: 4'b1111};
        vecs[2] = '{rst: 1'b0, req: 16'h0000, sel: 8'hE4, en: 4'b0000};
        vecs[3] = '{rst: 1'b1, req: 16'h0202, sel: 8'hE1, en: 4'b0001};
        vecs[4] = '{rst: 1'b0, req: 16'h0202, sel: 8'hD8, en: 4'b0100};
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst) do_reset();
            m = model(vecs[v].req);
            sched(vecs[v].req, vecs[v].sel, vecs[v].en);
        end
        // start pulses in cycles 2 and 5 plus a voq_req change in cycle 2 must be ignored
        do_reset();
        tmp.sel = 8'hE1; tmp.en = 4'b0001;
        m = model(16'h0202);
        sbq.push_back(tmp);
        voq_req = 16'h0202; start = 1'b1;
        tick(); start = 1'b0;
        tick(); start = 1'b1; voq_req = 16'hFFFF;
        tick(); start = 1'b0;
        chk("ign_valid_c3", sched_valid, 0);
        tick();
        chk("ign_valid_c4", sched_valid, 0);
        tick();
        chk("ign_valid_c5", sched_valid, 1);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("ign_busy_c6", busy, 0);
        chk("ign_valid_c6", sched_valid, 0);
        tick();
        chk("ign_busy_c7", busy, 0);
        chk("ign_sb", sbq.size(), 0);
        // Reset in cycle 3 of MATCH after pointers and rr_base have moved
        do_reset();
        m = model(16'hFFFF); sched(16'hFFFF, 8'hE4, 4'hF);
        m = model(16'hFFFF); sched(16'hFFFF, 8'h93, 4'hF);
        voq_req = 16'hFFFF; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick(); reset = 1'b0;
        m_base = 0;
        for (int i = 0; i < N; i++) m_ptr[i] = 0;
        chk("abort_sel", sched_sel, 8'hE4);
        chk("abort_en", sched_en, 0);
        chk("abort_valid", sched_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (3) begin
            tick();
            chk("abort_no_valid", sched_valid, 0);
        end
        m = model(16'hFFFF);
        sched(16'hFFFF, 8'hE4, 4'hF);
        for (int t = 0; t < 12; t++) begin
            r = 16'($urandom);
            if (t % 3 == 0) r = r & 16'($urandom);
            m = model(r);
            sched(r, m.sel, m.en);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/crossbar_scheduler.md
Name: crossbar_scheduler

Overview:
Produces the per-ingress egress selection and enable vectors that drive the crossbar's sched_sel and crossbar_in_en inputs. On each start pulse it latches the virtual-output-queue request matrix and builds a conflict-free ingress-to-egress matching. The matching is built by sequential round-robin arbitration, one egress per cycle. sched_sel is always a full permutation, so no two ingresses ever drive the same egress lane, including unmatched ones.

Parameters:
EGRESS_CNT, 4, number of ports (ingress count = egress count); power of two, >= 2.
SEL_W, $clog2(EGRESS_CNT), width of one select field (derived; not overridden).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new schedule; honoured only in IDLE.
voq_req  input  EGRESS_CNT*EGRESS_CNT  bit i*EGRESS_CNT+j = ingress i holds a packet for egress j.
sched_sel  output  SEL_W*EGRESS_CNT  field i = egress assigned to ingress i; registered.
sched_en  output  EGRESS_CNT  bit i = ingress i won a grant (feeds crossbar_in_en); registered.
sched_valid  output  1  one-cycle pulse when a new sched_sel/sched_en pair is presented.
busy  output  1  high from the first MATCH cycle through the DONE cycle.

Behaviour:
- Reset values:
  - sched_sel = identity (field i = i; 8'hE4 for 4 ports).
  - sched_en = 0, sched_valid = 0, busy = 0.
  - All grant pointers = 0, rr_base = 0, FSM = IDLE.
- State per egress k: grant_ptr[k] (SEL_W bits). Global: rr_base (SEL_W bits), matched-ingress mask, matched-egress mask, working select/enable copies.
- FSM states: IDLE, MATCH, DONE.
- IDLE:
  - On start=1, latch voq_req into req_q, clear the working masks and copies, clear the step counter, go to MATCH.
  - start=0 holds IDLE.
- MATCH runs exactly EGRESS_CNT cycles. At step c (0..EGRESS_CNT-1):
  - Process egress k = (rr_base + c) mod EGRESS_CNT.
  - Search ingress i = grant_ptr[k], grant_ptr[k]+1, ... (mod EGRESS_CNT) for the first i with req_q[i*EGRESS_CNT+k]=1 and i not already matched.
  - If found: work_sel[i] = k, work_en[i] = 1, mark i and k matched, grant_ptr[k] = (i+1) mod EGRESS_CNT.
  - If none found: grant_ptr[k] is unchanged and k stays unmatched.
  - After the last step, go to DONE.
- DONE (one cycle):
  - Fill: each unmatched ingress, in ascending index order, is assigned the lowest-index still-unmatched egress. Its enable stays 0.
  - Filled working copies are registered into sched_sel/sched_en so they are valid on the DONE cycle.
  - sched_valid = 1 for this cycle only.
  - rr_base increments mod EGRESS_CNT (wrap from EGRESS_CNT-1 to 0).
  - Next state is IDLE.
- Latency: start sampled in cycle 0; MATCH in cycles 1..EGRESS_CNT; DONE/sched_valid in cycle EGRESS_CNT+1 (cycle 5 for 4 ports); back to IDLE in cycle EGRESS_CNT+2.
- sched_sel/sched_en hold their values between DONE cycles.
- start during busy is ignored, not queued. start high in the DONE cycle is also ignored.
- Changes to voq_req after the start cycle have no effect on the current schedule.
- All-zero request matrix: completes normally; sched_en = 0, sched_sel = identity, rr_base still advances.
- Reset mid-operation: aborts immediately. No sched_valid. Every output, pointer and rr_base returns to its reset value.
- Invariant: sched_sel fields are pairwise distinct at all times.

Test Plan:
- Reset -> sched_sel=8'hE4, sched_en=4'b0000, sched_valid=0, busy=0.
- Reset, voq_req=16'hFFFF, start at cycle 0 -> busy cycles 1-5; sched_valid only in cycle 5; sched_sel=8'hE4, sched_en=4'b1111; grant_ptr={0,3,2,1} for egress 3..0; rr_base=1.
- Immediately repeat all-ones schedule -> egress order 1,2,3,0 grants ingress 2,3,0,1; sched_sel=8'h93, sched_en=4'b1111.
- Reset, voq_req bits 1 and 9 set (ingress 0 and 2 want egress 1), start -> sched_en=4'b0001, sched_sel=8'hE1 (ingress 1,2,3 filled to 0,2,3). Repeat start -> ingress 2 wins: sched_en=4'b0100, sched_sel field2=1, no duplicate fields.
- start pulsed in cycles 2 and 5 of a schedule, and voq_req changed in cycle 2 -> single sched_valid in cycle 5; result reflects the cycle-0 voq_req; FSM IDLE in cycle 6.
- reset asserted in cycle 3 of MATCH -> no sched_valid; outputs return to reset values. Next start with 16'hFFFF yields sched_sel=8'hE4, as after a fresh reset.
